noise_gate: RTL
===============

NOISE_GATE -- requirements
Module: noise_gate

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width, signed two's complement.
REQ-002 SHALL have parameter ENV_SHIFT, default 6, meaning envelope smoothing shift (time constant = 2^ENV_SHIFT samples).
REQ-003 SHALL have parameter HOLD_SAMPLES, default 2400, meaning samples held open after the envelope drops below close threshold.
REQ-004 SHALL have parameter ATTACK_STEP, default 32, meaning gain increment per sample in ATTACK (gain unity = 256).
REQ-005 SHALL have parameter RELEASE_STEP, default 1, meaning gain decrement per sample in RELEASE.
REQ-006 SHALL have port clk  input  1  single clock for all state.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid  input  1  one-cycle strobe marking a new input sample.
REQ-009 SHALL have port in_sample  input  DATA_W  signed sample from the ADC capture stage.
REQ-010 SHALL have port thr_open  input  DATA_W-1  unsigned envelope level that opens the gate.
REQ-011 SHALL have port thr_close  input  DATA_W-1  unsigned envelope level below which closing starts.
REQ-012 SHALL have port out_valid  output  1  strobe, registered copy of in_valid.
REQ-013 SHALL have port out_sample  output  DATA_W  signed gated sample, feeding the effects pipeline input.
REQ-014 SHALL have port gate_open  output  1  high in ATTACK, OPEN, HOLD.

Function
REQ-015 SHALL update state only on cycles with in_valid=1; all other cycles hold every register except out_valid.
REQ-016 SHALL compute |in_sample| as DATA_W-1 unsigned, most negative value saturating to 2^(DATA_W-1)-1.
REQ-017 SHALL update env <= env + ((|x| - env) >>> ENV_SHIFT), signed difference, arithmetic shift, result clamped to [0, 2^(DATA_W-1)-1].
REQ-018 SHALL use the updated env (env_next) for all threshold comparisons in the same cycle.
REQ-019 SHALL implement states CLOSED, ATTACK, OPEN, HOLD, RELEASE with 9-bit gain in [0,256].
REQ-020 SHALL transition CLOSED->ATTACK when env_next >= thr_open.
REQ-021 SHALL in ATTACK add ATTACK_STEP to gain, saturating at 256; on reaching 256 go to OPEN.
REQ-022 SHALL transition OPEN->HOLD when env_next < thr_close, loading hold counter with HOLD_SAMPLES-1.
REQ-023 SHALL in HOLD return to OPEN if env_next >= thr_open, else decrement counter; at counter 0 go to RELEASE.
REQ-024 SHALL in RELEASE go to ATTACK if env_next >= thr_open, else subtract RELEASE_STEP from gain saturating at 0; on reaching 0 go to CLOSED.
REQ-025 SHALL give the open test priority when thr_close > thr_open (misconfigured hysteresis); no state may oscillate within one sample.
REQ-026 SHALL output out_sample = (in_sample * gain_current) >>> 8, gain_current being gain before this sample's update, registered, latency 1 cycle.
REQ-027 SHALL produce out_sample exactly equal to in_sample when gain=256 and exactly 0 when gain=0.
REQ-028 SHALL hold out_sample between strobes.

Reset
REQ-029 SHALL on rst_n=0 immediately set state=CLOSED, gain=0, env=0, hold counter=0, out_valid=0, out_sample=0, gate_open=0.
REQ-030 SHALL discard any in-flight sample when reset asserts mid-operation; first valid after release uses reset values.

Structure
REQ-031 SHALL place the state enum, GAIN_UNITY=256 and GAIN_W=9 in shared package effects_pkg.
REQ-032 SHALL factor the envelope follower (abs, smoothing, clamp) into sub-module envelope_follower.
REQ-033 SHALL use one DATA_W x GAIN_W signed multiplier, no other arithmetic beyond adders/comparators.

Verification
REQ-034 SHALL test reset: assert rst_n=0 mid-ATTACK -> all outputs 0, state CLOSED within the same cycle.
REQ-035 SHALL test open: ENV_SHIFT=2, thr_open=1000, repeated in_sample=4000 -> env 1000,1750,...; ATTACK on first strobe, gain 0,32,...,256, OPEN after 8 ATTACK samples, out_sample=4000.
REQ-036 SHALL test hold/release: from OPEN, in_sample=0, thr_close=500, HOLD_SAMPLES=4, RELEASE_STEP=64 -> HOLD 4 samples, then gain 192,128,64,0, CLOSED, out_sample 0.
REQ-037 SHALL test retrigger: in RELEASE at gain 128 apply in_sample=-32768 -> ATTACK, gain 160 next, no output glitch.
REQ-038 SHALL test saturation: in_sample=-32768 at gain 256 -> out_sample=-32768; env never exceeds 32767.
REQ-039 SHALL test strobe gating: in_valid low for 10 cycles -> state, gain, out_sample unchanged, out_valid 0.

Source files
------------

// File: rtl/effects_pkg.sv
// Shared types and constants for the effects-chain front end (noise gate and friends).
// Gain is unsigned Q1.8: GAIN_UNITY means a gain of exactly 1.0.
package effects_pkg;

    localparam int GAIN_W     = 9;
    localparam int GAIN_UNITY = 256;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } gate_state_e;

    function automatic logic is_gate_open(input gate_state_e s);
        return (s == ST_ATTACK) || (s == ST_OPEN) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/envelope_follower.sv
// One-pole envelope follower: env += (|x| - env) >>> ENV_SHIFT, kept in [0, 2^(DATA_W-1)-1].
// env_next_o is the value the register takes on this strobe, so callers can compare against it.
module envelope_follower #(
    parameter int DATA_W    = 16,
    parameter int ENV_SHIFT = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] sample_i,
    output logic        [DATA_W-2:0] env_next_o
);

    localparam logic        [DATA_W-2:0] ENV_MAX  = '1;
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic        [DATA_W-2:0] abs_x;
    logic        [DATA_W-2:0] env_q;
    logic        [DATA_W-2:0] env_d;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W:0]   step;
    logic signed [DATA_W:0]   sum;

    always_comb begin
        // -2^(DATA_W-1) has no positive twin, so it pins to full scale.
        if (sample_i == MOST_NEG) begin
            abs_x = ENV_MAX;
        end else if (sample_i[DATA_W-1]) begin
            abs_x = (DATA_W-1)'(-sample_i);
        end else begin
            abs_x = sample_i[DATA_W-2:0];
        end

        diff = $signed({2'b00, abs_x}) - $signed({2'b00, env_q});
        step = diff >>> ENV_SHIFT;
        sum  = $signed({2'b00, env_q}) + step;

        if (sum[DATA_W]) begin
            env_d = '0;
        end else if (sum[DATA_W-1]) begin
            env_d = ENV_MAX;
        end else begin
            env_d = sum[DATA_W-2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_q <= '0;
        end else if (en_i) begin
            env_q <= env_d;
        end
    end

    assign env_next_o = env_d;

endmodule

// File: rtl/noise_gate.sv
// Noise gate: envelope-driven gain FSM (closed/attack/open/hold/release) applied to the sample stream.
// All state advances only on in_valid strobes; out_sample uses the gain in force before the strobe.
module noise_gate
    import effects_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ENV_SHIFT    = 6,
    parameter int HOLD_SAMPLES = 2400,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic        [DATA_W-2:0] thr_open,
    input  logic        [DATA_W-2:0] thr_close,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     gate_open
);

    localparam int                HOLD_W    = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES - 1);
    localparam int                PROD_W    = DATA_W + GAIN_W + 1;

    gate_state_e              state_q, state_d;
    logic        [GAIN_W-1:0] gain_q, gain_d;
    logic        [HOLD_W-1:0] hold_q, hold_d;
    logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
    logic                     out_valid_q;

    logic        [DATA_W-2:0] env_next;
    logic                     open_hit;
    logic                     close_hit;
    logic        [GAIN_W:0]   gain_up;
    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;

    envelope_follower #(
        .DATA_W    (DATA_W),
        .ENV_SHIFT (ENV_SHIFT)
    ) u_env (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (in_valid),
        .sample_i   (in_sample),
        .env_next_o (env_next)
    );

    assign open_hit   = (env_next >= thr_open);
    assign close_hit  = (env_next < thr_close);
    assign gain_up    = {1'b0, gain_q} + (GAIN_W+1)'(ATTACK_STEP);

    assign sample_ext = PROD_W'(in_sample);
    assign gain_ext   = PROD_W'($signed({1'b0, gain_q}));
    assign prod       = sample_ext * gain_ext;

    always_comb begin
        state_d      = state_q;
        gain_d       = gain_q;
        hold_d       = hold_q;
        out_sample_d = out_sample_q;

        if (in_valid) begin
            out_sample_d = DATA_W'(prod >>> 8);

            // Open test is checked first everywhere so inverted thresholds cannot ping-pong.
            unique case (state_q)
                ST_CLOSED: begin
                    if (open_hit) state_d = ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (gain_up >= (GAIN_W+1)'(GAIN_UNITY)) begin
                        gain_d  = GAIN_W'(GAIN_UNITY);
                        state_d = ST_OPEN;
                    end else begin
                        gain_d = gain_up[GAIN_W-1:0];
                    end
                end
                ST_OPEN: begin
                    if (!open_hit && close_hit) begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (open_hit) begin
                        state_d = ST_OPEN;
                    end else if (hold_q == '0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (open_hit) begin
                        state_d = ST_ATTACK;
                    end else if ({1'b0, gain_q} <= (GAIN_W+1)'(RELEASE_STEP)) begin
                        gain_d  = '0;
                        state_d = ST_CLOSED;
                    end else begin
                        gain_d = gain_q - GAIN_W'(RELEASE_STEP);
                    end
                end
                default: begin
                    state_d = ST_CLOSED;
                    gain_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLOSED;
            gain_q       <= '0;
            hold_q       <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            hold_q       <= hold_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= in_valid;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign gate_open  = is_gate_open(state_q);

endmodule
